cross_bar_arbiter: RTL

- Generates the per-slave and per-master mux selects for the combinational crossbar datapath.
- Decodes each master's target slave from its address MSBs.
- Arbitrates independently per slave with round-robin fairness and holds each grant until the slave acks the transaction.
- Sits beside the crossbar in the top; its slave_mux/master_mux outputs drive the crossbar select inputs directly.

---
 rtl/cross_bar_pkg.sv | 30 +++
 rtl/cross_bar_rr_arb.sv | 51 +++++
 rtl/cross_bar_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cross_bar_pkg.sv
// Shared sizes and types for the crossbar and its select arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Index types are one bit wider than log2(N) so that N itself fits and the
// value 0 can stay reserved for "disconnected".
package cross_bar_pkg;

  localparam int MASTER_N     = 4;
  localparam int SLAVE_N      = 4;
  localparam int MASTER_W     = $clog2(MASTER_N);
  localparam int SLAVE_W      = $clog2(SLAVE_N);
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;

  // slave_mux carries a master number, master_mux carries a slave number
  localparam int SLAVE_MUX_W  = MASTER_W + 1;
  localparam int MASTER_MUX_W = SLAVE_W + 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [MASTER_W:0] master_num_t;
  typedef logic [SLAVE_W:0]  slave_num_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cross_bar_rr_arb.sv
// Round-robin picker: first requester after ptr, wrapping, skipping mask.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take the result.
//
// Ports:
//   req       in  [MASTER_N:1]  candidate requests
//   ptr       in  master_num_t  last served master (1..MASTER_N)
//   mask      in  master_num_t  master to exclude, 0 = exclude none
//   gnt_valid out 1             at least one eligible requester
//   gnt       out master_num_t  winning master number, 0 when none
module cross_bar_rr_arb
  import cross_bar_pkg::*;
(
  input  logic [MASTER_N:1] req,
  input  master_num_t       ptr,
  input  master_num_t       mask,
  output logic              gnt_valid,
  output master_num_t       gnt
);

  logic [MASTER_N:1] w_elig;
  logic              w_hi_vld;
  logic              w_lo_vld;
  master_num_t       w_hi_gnt;
  master_num_t       w_lo_gnt;

  // Two ascending scans: the lowest eligible master above ptr wins outright;
  // failing that, the lowest eligible master at or below ptr (the wrap-around).
  always_comb begin
    w_elig   = '0;
    w_hi_vld = 1'b0;
    w_lo_vld = 1'b0;
    w_hi_gnt = '0;
    w_lo_gnt = '0;
    for (int m = 1; m <= MASTER_N; m++) begin
      w_elig[m] = req[m] && (master_num_t'(m) != mask);
      if (w_elig[m] && (master_num_t'(m) > ptr) && !w_hi_vld) begin
        w_hi_vld = 1'b1;
        w_hi_gnt = master_num_t'(m);
      end
      if (w_elig[m] && (master_num_t'(m) <= ptr) && !w_lo_vld) begin
        w_lo_vld = 1'b1;
        w_lo_gnt = master_num_t'(m);
      end
    end
  end

  assign gnt_valid = w_hi_vld || w_lo_vld;
  assign gnt       = w_hi_vld ? w_hi_gnt : w_lo_gnt;

endmodule

// File: rtl/cross_bar_arbiter.sv
// Per-slave round-robin arbiter producing crossbar mux selects.
// Latency: request to slave_mux 1 cycle; ack to next grant 1 cycle (back-to-back).
// Backpressure: a grant is held until the slave acks or the master drops req.
//
// Ports:
//   clk          in  1                              clock
//   aresetn      in  1                              async active-low reset
//   master_req   in  [MASTER_N:1]                   request per master
//   master_addr  in  addr_t [MASTER_N:1]            address per master, MSBs pick the slave
//   slave_ack    in  [SLAVE_N:1]                    transaction ack per slave
//   slave_mux    out [SLAVE_N:1][SLAVE_MUX_W-1:0]   master driving slave s, 0 = none (registered)
//   master_mux   out [MASTER_N:1][MASTER_MUX_W-1:0] slave returning to master m, 0 = none
module cross_bar_arbiter
  import cross_bar_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic [MASTER_N:1]                    master_req,
  input  addr_t [MASTER_N:1]                   master_addr,
  input  logic [SLAVE_N:1]                     slave_ack,
  output logic [SLAVE_N:1][SLAVE_MUX_W-1:0]    slave_mux,
  output logic [MASTER_N:1][MASTER_MUX_W-1:0]  master_mux
);

  slave_num_t w_target [MASTER_N:1];
  logic       w_unused_addr;

  // Only the top SLAVE_W address bits select the slave
  assign w_unused_addr = ^master_addr;

  always_comb begin
    for (int m = 1; m <= MASTER_N; m++) begin
      w_target[m] = {1'b0, master_addr[m][ADDR_W-1 -: SLAVE_W]} + slave_num_t'(1);
    end
  end

  for (genvar s = 1; s <= SLAVE_N; s++) begin : g_slave
    logic [MASTER_N:1] w_req_vec;
    logic              w_done;
    logic              w_win_vld;
    master_num_t       w_win;
    master_num_t       w_arb_ptr;
    master_num_t       w_arb_mask;
    arb_state_t        r_state;
    master_num_t       r_gnt;
    master_num_t       r_ptr;

    always_comb begin
      w_req_vec = '0;
      for (int m = 1; m <= MASTER_N; m++) begin
        w_req_vec[m] = master_req[m] && (w_target[m] == slave_num_t'(s));
      end
    end

    // A completing master becomes the new pointer immediately so the
    // back-to-back re-arbitration already starts searching after it.
    assign w_done     = (r_state == ARB_BUSY) && slave_ack[s] && master_req[r_gnt];
    assign w_arb_ptr  = w_done ? r_gnt : r_ptr;
    assign w_arb_mask = w_done ? r_gnt : '0;

    cross_bar_rr_arb u_rr_arb (
      .req       (w_req_vec),
      .ptr       (w_arb_ptr),
      .mask      (w_arb_mask),
      .gnt_valid (w_win_vld),
      .gnt       (w_win)
    );

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        r_state <= ARB_IDLE;
        r_gnt   <= '0;
        r_ptr   <= master_num_t'(MASTER_N);
      end else begin
        case (r_state)
          ARB_IDLE: begin
            if (w_win_vld) begin
              r_state <= ARB_BUSY;
              r_gnt   <= w_win;
            end
          end
          ARB_BUSY: begin
            if (w_done) begin
              r_ptr <= r_gnt;
              if (w_win_vld) begin
                r_gnt <= w_win;
              end else begin
                r_state <= ARB_IDLE;
                r_gnt   <= '0;
              end
            end else if (!master_req[r_gnt]) begin
              // Abandoned request: release without touching the pointer
              r_state <= ARB_IDLE;
              r_gnt   <= '0;
            end
          end
          default: begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
          end
        endcase
      end
    end

    assign slave_mux[s] = r_gnt;
  end

  // Inverse map; scanning downwards lets the lowest matching slave win
  always_comb begin
    master_mux = '0;
    for (int m = 1; m <= MASTER_N; m++) begin
      for (int s = SLAVE_N; s >= 1; s--) begin
        if (slave_mux[s] == master_num_t'(m)) begin
          master_mux[m] = slave_num_t'(s);
        end
      end
    end
  end

`ifndef SYNTHESIS
  logic w_dup_grant;

  always_comb begin
    w_dup_grant = 1'b0;
    for (int a = 1; a <= SLAVE_N; a++) begin
      for (int b = a + 1; b <= SLAVE_N; b++) begin
        if ((slave_mux[a] != '0) && (slave_mux[a] == slave_mux[b])) begin
          w_dup_grant = 1'b1;
        end
      end
    end
  end

  a_no_dup_grant: assert property (@(posedge clk) disable iff (!aresetn) !w_dup_grant);
`endif

endmodule
